// File: rtl/aes_decrypt_pipelined_if.sv
// Block/result handshake bundle for the pipelined AES-128 inverse cipher.
// The master side supplies ciphertext blocks and accepts plaintext results.
// The slave side is the decryptor.
interface aes_decrypt_pipelined_if #(
    parameter int TAG_W = 8
);
    logic [127:0]     data;        // ciphertext block
    logic             data_valid;  // data/data_tag valid this cycle
    logic [TAG_W-1:0] data_tag;    // sideband tag travelling with the block
    logic             in_ready;    // pipeline accepts input this cycle
    logic [127:0]     out;         // plaintext block
    logic [TAG_W-1:0] out_tag;     // tag of the block on out
    logic             done;        // out/out_tag valid
    logic             out_ready;   // downstream accepts out this cycle

    modport master (
        output data, data_valid, data_tag, out_ready,
        input  in_ready, out, out_tag, done
    );

    modport slave (
        input  data, data_valid, data_tag, out_ready,
        output in_ready, out, out_tag, done
    );
endinterface

// File: rtl/aes_decrypt_pipelined.sv
// Fully pipelined AES-128 inverse cipher, one block per cycle.
// Eleven register stages (initial AddRoundKey, nine full rounds, final round)
// carry data, tag and valid together. The whole pipeline freezes only while a
// finished block sits on the output and downstream is not ready; bubbles keep
// flowing otherwise. State byte 0 is data[127:120], column-major.
module aes_decrypt_pipelined #(
    parameter int Nk    = 4,
    parameter int Nr    = 10,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [(Nr+1)*128-1:0] allKeys,
    aes_decrypt_pipelined_if.slave bus
);

    if (Nk != 4 || Nr != 10) begin : g_param_check
        $error("aes_decrypt_pipelined supports only AES-128 (Nk=4, Nr=10)");
    end

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    // Inverse S-box: undo the affine transform, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    // Row r rotates right by r columns: new[r][c] = old[r][c-r].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [Nr:0][127:0]     stage_data;
    logic [Nr:0][TAG_W-1:0] stage_tag;
    logic [Nr:0]            stage_valid;
    logic [127:0]           stage_next [0:Nr];
    logic                   advance;

    // A held result is the only thing that can stall the pipe; bubbles never do.
    assign advance      = !stage_valid[Nr] || bus.out_ready;
    assign bus.in_ready = advance;
    assign bus.out      = stage_data[Nr];
    assign bus.out_tag  = stage_tag[Nr];
    assign bus.done     = stage_valid[Nr];

    // Stage i consumes round key Nr-i, which sits at allKeys[i*128 +: 128]
    // because key0 occupies the top 128 bits of the bus.
    assign stage_next[0] = bus.data ^ allKeys[0 +: 128];

    for (genvar i = 1; i <= Nr; i++) begin : g_round
        logic [127:0] keyed;
        assign keyed = inv_sub_bytes(inv_shift_rows(stage_data[i-1])) ^ allKeys[i*128 +: 128];
        if (i == Nr) begin : g_last
            assign stage_next[i] = keyed;
        end else begin : g_mid
            assign stage_next[i] = inv_mix_columns(keyed);
        end
    end

    // Pipeline registers: shift one stage per advancing cycle, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: data and tag stages are cleared too, not just valid, so out/out_tag read 0 after reset.
            stage_data  <= '0;
            stage_tag   <= '0;
            stage_valid <= '0;
        end else if (advance) begin
            // NOTE: non-blocking assignments let every stage read its predecessor's old value.
            stage_data[0]  <= stage_next[0];
            stage_tag[0]   <= bus.data_tag;
            stage_valid[0] <= bus.data_valid;
            for (int i = 1; i <= Nr; i++) begin
                stage_data[i]  <= stage_next[i];
                stage_tag[i]   <= stage_tag[i-1];
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

endmodule

// File: tb/tb_aes_decrypt_pipelined.sv
// Self-checking bench for aes_decrypt_pipelined: FIPS-197 vectors, bubbles,
// streaming, back-pressure, mid-flight reset and encrypt/decrypt loopback.
module tb_aes_decrypt_pipelined;

    localparam int TAG_W = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [1407:0] all_keys;
    int            cyc = 0;

    aes_decrypt_pipelined_if #(.TAG_W(TAG_W)) bus ();

    aes_decrypt_pipelined #(.Nk(4), .Nr(10), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .allKeys (all_keys),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0]     pt;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   xfer_cyc[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference forward cipher ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] i;
        for (int k = 0; k < 254; k++) r = gmul(r, x);
        i = (x == 8'h00) ? 8'h00 : r;
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [1407:0] key_expand(input logic [127:0] key);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rcon = 8'h01;
        logic [1407:0] ks;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ks[(10-r)*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ks);
        logic [127:0] s, o;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ ks[10*128 +: 128];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            s = o;
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
                    o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
                s = o;
            end
            s ^= ks[(10-rnd)*128 +: 128];
        end
        return s;
    endfunction

    // ---------------- output monitor / scoreboard ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset && bus.done && bus.out_ready) begin
            xfer_cyc.push_back(cyc);
            check("pending_before_out", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("out_data", bus.out, mon_e.pt);
                check("out_tag", 128'(bus.out_tag), 128'(mon_e.tag));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_at(input int t);
        while (cyc < t) next_cycle();
    endtask

    task automatic at_cycle(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic send(input logic [127:0] ct, input logic [TAG_W-1:0] tag, input logic [127:0] pt,
                        input bit push, input bit rand_bp, output int acc_cyc);
        int guard = 0;
        exp_t e;
        bus.data       = ct;
        bus.data_tag   = tag;
        bus.data_valid = 1'b1;
        if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            guard++;
        end
        check("send_accepted", 128'(bus.in_ready), 128'(1));
        acc_cyc = cyc;
        if (push) begin
            e.pt  = pt;
            e.tag = tag;
            exp_q.push_back(e);
        end
        next_cycle();
    endtask

    task automatic idle();
        bus.data_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        for (int k = 0; k < bound && exp_q.size() != 0; k++) @(negedge clk);
        check({name, "_drained"}, 128'(exp_q.size()), 128'(0));
        repeat (14) @(negedge clk);
        next_cycle();
    endtask

    function automatic int xfer_at(input int k);
        return (k < xfer_cyc.size()) ? xfer_cyc[k] : -1;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int c, c2, c0;
        logic [127:0] pt, ct;
        logic [1407:0] ks;

        reset          = 1'b0;
        bus.data       = '0;
        bus.data_tag   = '0;
        bus.data_valid = 1'b0;
        bus.out_ready  = 1'b1;
        all_keys       = key_expand(128'h000102030405060708090a0b0c0d0e0f);
        #2 reset = 1'b1;
        #10;
        check("rst_done", 128'(bus.done), 128'(0));
        check("rst_out", bus.out, 128'(0));
        check("rst_out_tag", 128'(bus.out_tag), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        repeat (2) next_cycle();
        reset = 1'b0;
        next_cycle();

        // T1: FIPS-197 C.1 inverse, exact latency
        xfer_cyc.delete();
        send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 8'h5A, 128'h00112233445566778899aabbccddeeff, 1, 0, c);
        idle();
        drain("t1", 50);
        check("t1_count", 128'(xfer_cyc.size()), 128'(1));
        check("t1_latency", 128'(xfer_at(0)), 128'(c + 11));

        // T2: FIPS-197 appendix B, block / bubble / block
        all_keys = key_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        xfer_cyc.delete();
        send(128'h3925841d02dc09fbdc118597196a0b32, 8'h01, 128'h3243f6a8885a308d313198a2e0370734, 1, 0, c);
        idle();
        next_cycle();
        send(128'h3925841d02dc09fbdc118597196a0b32, 8'h02, 128'h3243f6a8885a308d313198a2e0370734, 1, 0, c2);
        idle();
        drain("t2", 50);
        check("t2_count", 128'(xfer_cyc.size()), 128'(2));
        check("t2_first", 128'(xfer_at(0)), 128'(c + 11));
        check("t2_second", 128'(xfer_at(1)), 128'(c + 13));

        // T3: 20-block back-to-back stream with random tags
        xfer_cyc.delete();
        c0 = 0;
        for (int i = 0; i < 20; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            send(encrypt(pt, all_keys), TAG_W'($urandom), pt, 1, 0, c);
            if (i == 0) c0 = c;
        end
        idle();
        drain("t3", 80);
        check("t3_count", 128'(xfer_cyc.size()), 128'(20));
        for (int k = 0; k < 20; k++) check("t3_consecutive", 128'(xfer_at(k)), 128'(c0 + 11 + k));

        // T4: 5 cycles of back-pressure while a result is held
        xfer_cyc.delete();
        pt = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        send(encrypt(pt, all_keys), 8'h41, pt, 1, 0, c);
        send(encrypt(~pt, all_keys), 8'h42, ~pt, 1, 0, c2);
        send(encrypt(pt ^ 128'h1, all_keys), 8'h43, pt ^ 128'h1, 1, 0, c2);
        idle();
        drive_at(c + 10);
        bus.out_ready = 1'b0;
        drive_at(c + 11);
        bus.data       = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        bus.data_tag   = 8'hEE;
        bus.data_valid = 1'b1;
        for (int k = 11; k <= 15; k++) begin
            at_cycle(c + k);
            check("t4_hold_done", 128'(bus.done), 128'(1));
            check("t4_hold_out", bus.out, pt);
            check("t4_hold_tag", 128'(bus.out_tag), 128'(8'h41));
            check("t4_in_ready", 128'(bus.in_ready), 128'(0));
        end
        drive_at(c + 16);
        bus.out_ready  = 1'b1;
        bus.data_valid = 1'b0;
        drain("t4", 50);
        check("t4_count", 128'(xfer_cyc.size()), 128'(3));
        check("t4_first", 128'(xfer_at(0)), 128'(c + 16));
        check("t4_second", 128'(xfer_at(1)), 128'(c + 17));
        check("t4_third", 128'(xfer_at(2)), 128'(c + 18));

        // T5: reset with 6 blocks in flight
        xfer_cyc.delete();
        c0 = 0;
        for (int i = 0; i < 6; i++) begin
            pt = {4{$urandom}};
            send(encrypt(pt, all_keys), TAG_W'(8'h60 + i), pt, 0, 0, c);
            if (i == 0) c0 = c;
        end
        idle();
        drive_at(c0 + 10);
        bus.out_ready = 1'b0;
        drive_at(c0 + 11);
        check("t5_pre_done", 128'(bus.done), 128'(1));
        #1 reset = 1'b1;
        #1;
        check("t5_async_done", 128'(bus.done), 128'(0));
        check("t5_async_out", bus.out, 128'(0));
        check("t5_async_tag", 128'(bus.out_tag), 128'(0));
        repeat (2) next_cycle();
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        next_cycle();
        pt = 128'hfedcba98765432100123456789abcdef;
        send(encrypt(pt, all_keys), 8'h77, pt, 1, 0, c);
        idle();
        drain("t5", 50);
        check("t5_count", 128'(xfer_cyc.size()), 128'(1));
        check("t5_latency", 128'(xfer_at(0)), 128'(c + 11));

        // T6: loopback of 100 random blocks under a random key, random back-pressure
        ks       = key_expand({$urandom, $urandom, $urandom, $urandom});
        all_keys = ks;
        xfer_cyc.delete();
        for (int i = 0; i < 100; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = encrypt(pt, ks);
            send(ct, TAG_W'(i), pt, 1, 1, c);
        end
        idle();
        bus.out_ready = 1'b1;
        drain("t6", 400);
        check("t6_count", 128'(xfer_cyc.size()), 128'(100));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
